// File: rtl/spi_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_regs_pkg
// Purpose  : Shared constants and FSM state type for the SPI register front end.
// Revision : 1.0
// ============================================================================
package spi_regs_pkg;

    localparam int FRAME_BITS = 16;
    localparam int NUM_REGS   = 5;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_PWM_LO    = 7'h02;
    localparam logic [6:0] ADDR_PWM_HI    = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    // Bit counter saturates one past a full frame so over-length frames stay visible.
    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_SAT  = 5'd17;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_peripheral_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_peripheral_if
// Purpose  : SPI pin bundle plus the five configuration register outputs.
// Revision : 1.0
// ============================================================================
interface spi_peripheral_if;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       cipo;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    modport master (
        output sclk, copi, ncs,
        input  cipo, en_reg_out_7_0, en_reg_out_15_8,
               en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
    );

    modport slave (
        input  sclk, copi, ncs,
        output cipo, en_reg_out_7_0, en_reg_out_15_8,
               en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
    );
endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Multi-flop synchronizer with a history flop for rise/fall pulses.
// Revision : 1.0
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic async_i,
    output logic      level_o,
    output logic      rise_o,
    output logic      fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule
`default_nettype wire

// File: rtl/spi_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : spi_peripheral
// Purpose  : SPI write-frame receiver driving five 8-bit PWM config registers.
//            Optional register readback on cipo when SPI_READBACK_EN is defined.
// Revision : 1.0
// ============================================================================
module spi_peripheral
    import spi_regs_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input wire logic         clk,
    input wire logic         rst_n,
    spi_peripheral_if.slave  bus
);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_copi_lvl, w_copi_rise, w_copi_fall;
    logic w_ncs_lvl,  w_ncs_rise,  w_ncs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .async_i(bus.sclk),
        .level_o(w_sclk_lvl), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .async_i(bus.copi),
        .level_o(w_copi_lvl), .rise_o(w_copi_rise), .fall_o(w_copi_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .async_i(bus.ncs),
        .level_o(w_ncs_lvl), .rise_o(w_ncs_rise), .fall_o(w_ncs_fall)
    );

    logic w_unused;
    assign w_unused = ^{w_sclk_lvl, w_sclk_fall, w_copi_rise, w_copi_fall};

    spi_state_t            state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [7:0]            regs_q [NUM_REGS];
    logic [7:0]            regs_d [NUM_REGS];
    logic                  w_commit;

`ifdef SPI_READBACK_EN
    logic [7:0] tx_q, tx_d;
    logic       cipo_q, cipo_d;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rd_data;

    // Address is complete on the 8th rise: seven held bits plus the bit arriving now.
    assign w_rd_addr = {shift_q[5:0], w_copi_lvl};

    always_comb begin
        w_rd_data = 8'h00;
        if (w_rd_addr <= MAX_ADDR) begin
            case (w_rd_addr)
                ADDR_EN_OUT_LO: w_rd_data = regs_q[0];
                ADDR_EN_OUT_HI: w_rd_data = regs_q[1];
                ADDR_PWM_LO:    w_rd_data = regs_q[2];
                ADDR_PWM_HI:    w_rd_data = regs_q[3];
                ADDR_DUTY:      w_rd_data = regs_q[4];
                default:        w_rd_data = 8'h00;
            endcase
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        regs_d   = regs_q;
        w_commit = 1'b0;
`ifdef SPI_READBACK_EN
        tx_d     = tx_q;
        cipo_d   = cipo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    state_d = ST_RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            ST_RECV: begin
                if (w_ncs_rise) begin
                    state_d  = ST_IDLE;
                    w_commit = (cnt_q == CNT_FULL) && shift_q[FRAME_BITS-1]
                               && (shift_q[14:8] <= MAX_ADDR);
`ifdef SPI_READBACK_EN
                    tx_d   = '0;
                    cipo_d = 1'b0;
`endif
                end else if (w_ncs_fall) begin
                    cnt_d   = '0;
                    shift_d = '0;
`ifdef SPI_READBACK_EN
                    tx_d   = '0;
                    cipo_d = 1'b0;
`endif
                end else if (w_sclk_rise && !w_ncs_lvl) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], w_copi_lvl};
                    if (cnt_q != CNT_SAT)
                        cnt_d = cnt_q + 5'd1;
`ifdef SPI_READBACK_EN
                    if (cnt_q == 5'd7 && !shift_q[6]) begin
                        cipo_d = w_rd_data[7];
                        tx_d   = {w_rd_data[6:0], 1'b0};
                    end
`endif
                end
`ifdef SPI_READBACK_EN
                // data[7] must stay put across the fall after rise 8; shifting starts after rise 9.
                else if (w_sclk_fall && cnt_q >= 5'd9 && cnt_q <= CNT_FULL) begin
                    cipo_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_commit) begin
            case (shift_q[14:8])
                ADDR_EN_OUT_LO: regs_d[0] = shift_q[7:0];
                ADDR_EN_OUT_HI: regs_d[1] = shift_q[7:0];
                ADDR_PWM_LO:    regs_d[2] = shift_q[7:0];
                ADDR_PWM_HI:    regs_d[3] = shift_q[7:0];
                ADDR_DUTY:      regs_d[4] = shift_q[7:0];
                default:        ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
`ifdef SPI_READBACK_EN
            tx_q    <= '0;
            cipo_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            regs_q  <= regs_d;
`ifdef SPI_READBACK_EN
            tx_q    <= tx_d;
            cipo_q  <= cipo_d;
`endif
        end
    end

`ifdef SPI_READBACK_EN
    assign bus.cipo = cipo_q;
`else
    assign bus.cipo = 1'b0;
`endif

    assign bus.en_reg_out_7_0  = regs_q[0];
    assign bus.en_reg_out_15_8 = regs_q[1];
    assign bus.en_reg_pwm_7_0  = regs_q[2];
    assign bus.en_reg_pwm_15_8 = regs_q[3];
    assign bus.pwm_duty_cycle  = regs_q[4];

endmodule
`default_nettype wire

// File: tb/tb_spi_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_peripheral
// Purpose  : Directed self-checking bench for spi_peripheral.
// Revision : 1.0
// ============================================================================
module tb_spi_peripheral;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [31:0] rx_bits;

    spi_peripheral_if bus ();

    spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each SCLK phase lasts 5 clk periods; cipo is captured just before each rise.
    task automatic send_bits(input logic [31:0] vec, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.copi = vec[i];
            idle(5);
            rx_bits  = {rx_bits[30:0], bus.cipo};
            bus.sclk = 1'b1;
            idle(5);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] vec, input int nbits);
        rx_bits = '0;
        bus.ncs = 1'b0;
        idle(5);
        send_bits(vec, nbits);
        idle(5);
        bus.ncs = 1'b1;
        idle(8);
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        check_eq({tag, ".out_lo"},  {24'h0, bus.en_reg_out_7_0},  {24'h0, e0});
        check_eq({tag, ".out_hi"},  {24'h0, bus.en_reg_out_15_8}, {24'h0, e1});
        check_eq({tag, ".pwm_lo"},  {24'h0, bus.en_reg_pwm_7_0},  {24'h0, e2});
        check_eq({tag, ".pwm_hi"},  {24'h0, bus.en_reg_pwm_15_8}, {24'h0, e3});
        check_eq({tag, ".duty"},    {24'h0, bus.pwm_duty_cycle},  {24'h0, e4});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rx_bits  = '0;
        bus.sclk = 1'b0;
        bus.copi = 1'b0;
        bus.ncs  = 1'b1;
        rst_n    = 1'b0;
        idle(4);
        check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_eq("reset.cipo", {31'h0, bus.cipo}, 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Basic write with latency: update lands on the 3rd clk edge after ncs rise.
        bus.ncs = 1'b0;
        idle(5);
        send_bits(32'h80FF, 16);
        idle(5);
        bus.ncs = 1'b1;
        idle(2);
        check_eq("latency.edge2", {24'h0, bus.en_reg_out_7_0}, 32'h00);
        idle(1);
        check_eq("latency.edge3", {24'h0, bus.en_reg_out_7_0}, 32'hFF);
        idle(6);
        check_regs("basic", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);

        frame(32'h8480, 16);
        frame(32'h820F, 16);
        check_regs("sweep", 8'hFF, 8'h00, 8'h0F, 8'h00, 8'h80);

        frame(32'h8155 >> 1, 15);
        check_regs("short15", 8'hFF, 8'h00, 8'h0F, 8'h00, 8'h80);
        frame({15'h0, 16'h8155, 1'b1}, 17);
        check_regs("long17", 8'hFF, 8'h00, 8'h0F, 8'h00, 8'h80);
        frame(32'h85AA, 16);
        check_regs("addr05", 8'hFF, 8'h00, 8'h0F, 8'h00, 8'h80);
        frame(32'h0133, 16);
        check_regs("read_nowrite", 8'hFF, 8'h00, 8'h0F, 8'h00, 8'h80);

        // Reset after 9 bits, release with ncs still low, finish the frame: must be dropped.
        bus.ncs = 1'b0;
        idle(5);
        send_bits(32'h83AB >> 7, 9);
        rst_n = 1'b0;
        idle(3);
        check_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        idle(3);
        send_bits(32'h83AB, 7);
        idle(5);
        bus.ncs = 1'b1;
        idle(8);
        check_regs("postrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        frame(32'h833C, 16);
        check_regs("rewrite", 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00);

        repeat (20) begin
            bus.sclk = 1'b1;
            idle(5);
            bus.sclk = 1'b0;
            idle(5);
        end
        bus.ncs = 1'b0;
        idle(4);
        bus.ncs = 1'b1;
        idle(8);
        check_regs("deselect", 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00);

        frame(32'h815A, 16);
        check_regs("wr01", 8'h00, 8'h5A, 8'h00, 8'h3C, 8'h00);
        frame(32'h0100, 16);
`ifdef SPI_READBACK_EN
        check_eq("read01.cipo", rx_bits & 32'hFFFF, 32'h005A);
`else
        check_eq("read01.cipo", rx_bits & 32'hFFFF, 32'h0000);
`endif
        check_regs("read01", 8'h00, 8'h5A, 8'h00, 8'h3C, 8'h00);
        frame(32'h1000, 16);
        check_eq("read10.cipo", rx_bits & 32'hFFFF, 32'h0000);
        check_eq("idle.cipo", {31'h0, bus.cipo}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
